alu_sequencer: RTL and testbench

Sequences the shared ALU datapath for the core. It accepts one operation at a time over a valid/ready request port and latches the operands. It drives the ALU's channel_A, channel_B and control inputs for an op-dependent number of cycles, so multiply, divide and modulo get timing slack. It then captures the result and owns the architectural NZCV status register, feeding its C bit back as the ALU's previous carry.

---
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issues one operation at a time to the shared ALU, holds its inputs for an
// op-dependent number of cycles, captures the result and owns the NZCV register.
module alu_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_control,
    input  logic [DATA_WIDTH-1:0] req_operand_A,
    input  logic [DATA_WIDTH-1:0] req_operand_B,
    input  logic                  req_set_flags,
    output logic [DATA_WIDTH-1:0] alu_channel_A,
    output logic [DATA_WIDTH-1:0] alu_channel_B,
    output logic [3:0]            alu_control,
    output logic                  alu_previous_carry,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_N,
    input  logic                  alu_Z,
    input  logic                  alu_C,
    input  logic                  alu_V,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [3:0]            flags_NZCV,
    output logic                  busy
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_counter;
    logic [3:0]            r_control;
    logic [DATA_WIDTH-1:0] r_operandA;
    logic [DATA_WIDTH-1:0] r_operandB;
    logic                  r_setFlags;
    logic [DATA_WIDTH-1:0] r_respResult;
    logic                  r_respValid;
    logic [3:0]            r_flags;

    logic [CW-1:0]         w_loadCount;
    logic                  w_writesC;
    logic                  w_writesV;

    // Counter preload is latency-1 so the completion edge lands exactly L edges after accept.
    always_comb begin
        w_loadCount = '0;
        case (req_control)
            4'd9:         w_loadCount = CW'(MUL_LATENCY - 1);
            4'd10, 4'd11: w_loadCount = CW'(DIV_LATENCY - 1);
            default:      w_loadCount = '0;
        endcase
    end

    // Only the arithmetic ops own C; divide/modulo additionally report divide-by-zero on V.
    always_comb begin
        w_writesC = 1'b0;
        w_writesV = 1'b0;
        case (r_control)
            4'd1, 4'd2, 4'd5, 4'd6, 4'd8: begin
                w_writesC = 1'b1;
                w_writesV = 1'b1;
            end
            4'd10, 4'd11: w_writesV = 1'b1;
            default: begin
                w_writesC = 1'b0;
                w_writesV = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_counter    <= '0;
            r_control    <= '0;
            r_operandA   <= '0;
            r_operandB   <= '0;
            r_setFlags   <= 1'b0;
            r_respResult <= '0;
            r_respValid  <= 1'b0;
            r_flags      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_control  <= req_control;
                        r_operandA <= req_operand_A;
                        r_operandB <= req_operand_B;
                        r_setFlags <= req_set_flags;
                        r_counter  <= w_loadCount;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_counter != '0) begin
                        r_counter <= r_counter - 1'b1;
                    end else begin
                        r_respResult <= alu_result;
                        r_respValid  <= 1'b1;
                        r_state      <= S_DONE;
                        if (r_setFlags) begin
                            r_flags[3] <= alu_N;
                            r_flags[2] <= alu_Z;
                            if (w_writesC) r_flags[1] <= alu_C;
                            if (w_writesV) r_flags[0] <= alu_V;
                        end
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The ALU sees zeros whenever no operation is in flight.
    assign alu_control        = (r_state == S_EXEC) ? r_control  : '0;
    assign alu_channel_A      = (r_state == S_EXEC) ? r_operandA : '0;
    assign alu_channel_B      = (r_state == S_EXEC) ? r_operandB : '0;
    assign alu_previous_carry = r_flags[1];

    assign req_ready   = (r_state == S_IDLE) && !reset;
    assign resp_valid  = r_respValid;
    assign resp_result = r_respResult;
    assign flags_NZCV  = r_flags;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives the datapath
// and a scoreboard queue holds expected results/flags per issued operation.
module tb_alu_sequencer;

    localparam int DW      = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [3:0]    flags;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_set_flags;
    logic [3:0]    req_control;
    logic [DW-1:0] req_operand_A, req_operand_B;
    logic [DW-1:0] alu_channel_A, alu_channel_B, alu_result;
    logic [3:0]    alu_control;
    logic          alu_previous_carry, alu_N, alu_Z, alu_C, alu_V;
    logic          resp_valid, resp_ready, busy;
    logic [DW-1:0] resp_result;
    logic [3:0]    flags_NZCV;
    logic [DW+3:0] aluOut;

    exp_t       sbQueue[$];
    logic [3:0] expFlags;
    int         compared   = 0;
    int         mismatched = 0;

    alu_sequencer #(
        .DATA_WIDTH (DW),
        .MUL_LATENCY(MUL_LAT),
        .DIV_LATENCY(DIV_LAT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_control       (req_control),
        .req_operand_A     (req_operand_A),
        .req_operand_B     (req_operand_B),
        .req_set_flags     (req_set_flags),
        .alu_channel_A     (alu_channel_A),
        .alu_channel_B     (alu_channel_B),
        .alu_control       (alu_control),
        .alu_previous_carry(alu_previous_carry),
        .alu_result        (alu_result),
        .alu_N             (alu_N),
        .alu_Z             (alu_Z),
        .alu_C             (alu_C),
        .alu_V             (alu_V),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_result       (resp_result),
        .flags_NZCV        (flags_NZCV),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: returns {N,Z,C,V,result}; C follows ARM no-borrow for subtraction.
    function automatic logic [DW+3:0] aluModel(input logic [3:0] ctrl, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic cin);
        logic [DW:0]   wide;
        logic [DW-1:0] res;
        logic          c, v;
        wide = '0; res = '0; c = 1'b0; v = 1'b0;
        case (ctrl)
            4'd1: begin
                wide = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
                res = wide[DW-1:0]; c = wide[DW];
                v = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            4'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                res = wide[DW-1:0]; c = wide[DW];
                v = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            4'd5: begin
                wide = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
                res = wide[DW-1:0]; c = wide[DW];
                v = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            4'd6: begin
                wide = {1'b0, ~a} + (DW+1)'(1);
                res = wide[DW-1:0]; c = wide[DW];
                v = a[DW-1] && res[DW-1];
            end
            4'd8: begin
                wide = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
                res = wide[DW-1:0]; c = wide[DW];
                v = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            4'd3:  res = a & b;
            4'd4:  res = a & ~b;
            4'd7:  res = a | b;
            4'd9:  res = a * b;
            4'd10: if (b == '0) v = 1'b1; else res = a / b;
            4'd11: if (b == '0) v = 1'b1; else res = a % b;
            4'd12: res = b;
            4'd13: res = a ^ b;
            4'd14: res = ((a != '0) && (b != '0)) ? DW'(1) : '0;
            default: res = a;
        endcase
        return {res[DW-1], (res == '0), c, v, res};
    endfunction

    always_comb aluOut = aluModel(alu_control, alu_channel_A, alu_channel_B, alu_previous_carry);
    assign alu_result = aluOut[DW-1:0];
    assign alu_N      = aluOut[DW+3];
    assign alu_Z      = aluOut[DW+2];
    assign alu_C      = aluOut[DW+1];
    assign alu_V      = aluOut[DW];

    // Pushes the expected outcome, issues one request and waits (bounded) for resp_valid.
    task automatic runOp(input logic [3:0] ctrl, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sf, output int cycles, output int held);
        logic [DW+3:0] m;
        exp_t          e;
        m = aluModel(ctrl, a, b, expFlags[1]);
        if (sf) begin
            expFlags[3] = m[DW+3];
            expFlags[2] = m[DW+2];
            if (ctrl inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd8}) expFlags[1] = m[DW+1];
            if (ctrl inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd10, 4'd11}) expFlags[0] = m[DW];
        end
        e.result = m[DW-1:0];
        e.flags  = expFlags;
        sbQueue.push_back(e);
        req_control = ctrl; req_operand_A = a; req_operand_B = b; req_set_flags = sf;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cycles = 0; held = 0;
        while (!resp_valid && cycles < 64) begin
            if (busy && alu_control == ctrl && alu_channel_A == a && alu_channel_B == b) held++;
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic ackResp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        compared++;
        if ({req_ready, resp_valid, busy, flags_NZCV, alu_control} !== 9'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got ready/valid/busy/flags/ctrl=%b expected 0", {req_ready, resp_valid, busy, flags_NZCV, alu_control});
        end
        compared++;
        if (resp_result !== '0) begin
            mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", resp_result);
        end
        reset = 1'b0;
        expFlags = 4'b0000;
        @(negedge clock);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_add();
        exp_t e; int cyc, held;
        runOp(4'd2, 32'd5, 32'd7, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (cyc !== 1 || held !== 1) begin
            mismatched++; $display("[TB] FAIL add_latency: got %0d/%0d cycles expected 1/1", cyc, held);
        end
        compared++;
        if (resp_result !== e.result || resp_result !== 32'd12) begin
            mismatched++; $display("[TB] FAIL add_result: got %h expected %h", resp_result, e.result);
        end
        compared++;
        if (flags_NZCV !== e.flags || flags_NZCV !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL add_flags: got %b expected %b", flags_NZCV, e.flags);
        end
        ackResp();
    endtask

    task automatic test_carry_chain();
        exp_t e; int cyc, held;
        runOp(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'd0 || flags_NZCV !== 4'b0110 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL add_carry: got %h/%b expected 0/0110", resp_result, flags_NZCV);
        end
        ackResp();
        runOp(4'd3, 32'hF000_0000, 32'hFFFF_FFFF, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'hF000_0000 || flags_NZCV !== 4'b1010 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL and_keepc: got %h/%b expected f0000000/1010", resp_result, flags_NZCV);
        end
        ackResp();
        compared++;
        if (alu_previous_carry !== 1'b1) begin
            mismatched++; $display("[TB] FAIL prev_carry: got %b expected 1", alu_previous_carry);
        end
        runOp(4'd1, 32'd1, 32'd1, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'd3 || flags_NZCV !== 4'b0000 || resp_result !== e.result) begin
            mismatched++; $display("[TB] FAIL adc: got %h/%b expected 3/0000", resp_result, flags_NZCV);
        end
        ackResp();
    endtask

    task automatic test_sub_noflags();
        exp_t e; int cyc, held;
        runOp(4'd5, 32'd3, 32'd5, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'hFFFF_FFFE || flags_NZCV !== 4'b1000 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL sub_flags: got %h/%b expected fffffffe/1000", resp_result, flags_NZCV);
        end
        ackResp();
        runOp(4'd2, 32'd1, 32'd2, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (flags_NZCV !== e.flags || resp_result !== e.result) begin
            mismatched++; $display("[TB] FAIL add_clear: got %h/%b expected %h/%b", resp_result, flags_NZCV, e.result, e.flags);
        end
        ackResp();
        runOp(4'd5, 32'd3, 32'd5, 1'b0, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'hFFFF_FFFE || flags_NZCV !== 4'b0000 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL sub_noflags: got %h/%b expected fffffffe/0000", resp_result, flags_NZCV);
        end
        ackResp();
    endtask

    task automatic test_div_mod();
        exp_t e; int cyc, held;
        runOp(4'd10, 32'd100, 32'd0, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (cyc !== DIV_LAT || held !== DIV_LAT) begin
            mismatched++; $display("[TB] FAIL div_latency: got %0d/%0d cycles expected %0d", cyc, held, DIV_LAT);
        end
        compared++;
        if (resp_result !== 32'd0 || flags_NZCV[0] !== 1'b1 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL div_zero: got %h/%b expected 0/%b", resp_result, flags_NZCV, e.flags);
        end
        ackResp();
        runOp(4'd11, 32'd100, 32'd7, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (cyc !== DIV_LAT || resp_result !== 32'd2 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL mod: got %h/%b after %0d expected 2/%b after %0d", resp_result, flags_NZCV, cyc, e.flags, DIV_LAT);
        end
        ackResp();
    endtask

    task automatic test_backpressure();
        exp_t e; int cyc, held;
        runOp(4'd9, 32'd6, 32'd7, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (cyc !== MUL_LAT || held !== MUL_LAT) begin
            mismatched++; $display("[TB] FAIL mul_latency: got %0d/%0d expected %0d", cyc, held, MUL_LAT);
        end
        req_control = 4'd2; req_operand_A = 32'd1; req_operand_B = 32'd1; req_set_flags = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (resp_valid !== 1'b1 || resp_result !== 32'd42 || req_ready !== 1'b0 || flags_NZCV !== e.flags) begin
                mismatched++; $display("[TB] FAIL mul_hold%0d: got v=%b %h rdy=%b %b expected 1 0000002a 0 %b", i, resp_valid, resp_result, req_ready, flags_NZCV, e.flags);
            end
            @(negedge clock);
        end
        ackResp();
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++; $display("[TB] FAIL mul_release: got v=%b rdy=%b expected 0 1", resp_valid, req_ready);
        end
        runOp(4'd2, 32'd1, 32'd1, 1'b0, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (cyc !== 1 || resp_result !== 32'd2 || resp_result !== e.result) begin
            mismatched++; $display("[TB] FAIL after_bp: got %h after %0d expected 2 after 1", resp_result, cyc);
        end
        ackResp();
    endtask

    task automatic test_reset_mid_op();
        exp_t e; int cyc, held;
        runOp(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (flags_NZCV !== 4'b0110 || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL pre_reset_flags: got %b expected 0110", flags_NZCV);
        end
        ackResp();
        req_control = 4'd10; req_operand_A = 32'd100; req_operand_B = 32'd7; req_set_flags = 1'b1;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL div_inflight: got busy=%b v=%b expected 1 0", busy, resp_valid);
        end
        reset = 1'b1;
        @(negedge clock);
        compared++;
        if ({busy, resp_valid, req_ready, flags_NZCV} !== 7'b0 || resp_result !== '0) begin
            mismatched++; $display("[TB] FAIL mid_reset: got busy/v/rdy/flags=%b result=%h expected 0", {busy, resp_valid, req_ready, flags_NZCV}, resp_result);
        end
        reset = 1'b0;
        expFlags = 4'b0000;
        @(negedge clock);
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL post_reset: got rdy=%b v=%b expected 1 0", req_ready, resp_valid);
        end
        runOp(4'd1, 32'd1, 32'd1, 1'b1, cyc, held);
        e = sbQueue.pop_front();
        compared++;
        if (resp_result !== 32'd2 || resp_result !== e.result || flags_NZCV !== e.flags) begin
            mismatched++; $display("[TB] FAIL adc_after_reset: got %h/%b expected 2/%b", resp_result, flags_NZCV, e.flags);
        end
        ackResp();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_control = '0;
        req_operand_A = '0; req_operand_B = '0; req_set_flags = 1'b0; expFlags = 4'b0000;
        test_reset();
        test_add();
        test_carry_chain();
        test_sub_noflags();
        test_div_mod();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
